lsu_issue_arbiter: RTL and testbench

- Multi-channel successor to the LSU datapath load/store packet selector.
- Accepts up to NUM_AGEN address-generated memory packets per cycle, plus one replay packet from the load-queue path.
- Issues at most one load and one store per cycle to the cache/queue paths through registered outputs.
- Loads that lose arbitration, and incoming replays, are buffered in a replay FIFO; a starvation counter forces replay priority.

---
 rtl/lsu_issue_arbiter.sv | 112 +++++++++++
 tb/tb_lsu_issue_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_issue_arbiter.sv
// lsu_issue_arbiter: picks one load and one store per cycle from AGEN channels, buffering losing loads and replays in a FIFO
//   inputs : clk, reset (async), recover_i (flush), agen_valid_i/agen_is_ld_i/agen_pkt_i (per channel), replay_valid_i/replay_pkt_i
//   outputs: agen_ready_o (comb), ld_valid_o/ld_pkt_o/ld_from_replay_o, st_valid_o/st_pkt_o (registered),
//            replay_count_o (FIFO occupancy), err_multi_st_o/err_overflow_o (sticky)
module lsu_issue_arbiter #(
  parameter int NUM_AGEN     = 2,
  parameter int PKT_W        = 128,
  parameter int REPLAY_DEPTH = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 recover_i,
  input  logic [NUM_AGEN-1:0]                  agen_valid_i,
  input  logic [NUM_AGEN-1:0]                  agen_is_ld_i,
  input  logic [NUM_AGEN*PKT_W-1:0]            agen_pkt_i,
  input  logic                                 replay_valid_i,
  input  logic [PKT_W-1:0]                     replay_pkt_i,
  output logic                                 agen_ready_o,
  output logic                                 ld_valid_o,
  output logic [PKT_W-1:0]                     ld_pkt_o,
  output logic                                 ld_from_replay_o,
  output logic                                 st_valid_o,
  output logic [PKT_W-1:0]                     st_pkt_o,
  output logic [$clog2(REPLAY_DEPTH+1)-1:0]    replay_count_o,
  output logic                                 err_multi_st_o,
  output logic                                 err_overflow_o
);
  localparam int AW = $clog2(REPLAY_DEPTH);
  localparam int CW = $clog2(REPLAY_DEPTH+1);
  localparam int SW = $clog2(STARVE_LIMIT+1);
  localparam int NP = NUM_AGEN + 1;
  logic [PKT_W-1:0]    r_fifo [REPLAY_DEPTH];
  logic [AW-1:0]       r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]       r_count;
  logic [SW-1:0]       r_starve;
  logic [NUM_AGEN-1:0] w_ld_mask, w_st_mask, w_ld_win, w_st_win;
  logic [NP-1:0]       w_push_req, w_wr_en;
  logic [PKT_W-1:0]    w_push_pkt [NP];
  logic [AW-1:0]       w_wr_idx [NP];
  logic [PKT_W-1:0]    w_ld_pkt, w_st_pkt;
  logic [CW-1:0]       w_free, w_npush;
  logic                w_ne, w_force, w_pop, w_overflow;
  assign agen_ready_o   = (CW'(REPLAY_DEPTH) - r_count) >= CW'(NP);
  assign replay_count_o = r_count;
  always_comb begin
    w_ld_mask  = recover_i ? '0 : agen_valid_i & agen_is_ld_i;
    w_st_mask  = recover_i ? '0 : agen_valid_i & ~agen_is_ld_i;
    w_st_win   = w_st_mask & (~w_st_mask + NUM_AGEN'(1));
    w_ne       = r_count != '0;
    w_force    = w_ne && r_starve == SW'(STARVE_LIMIT);
    w_pop      = !recover_i && w_ne && (w_force || w_ld_mask == '0);
    w_ld_win   = w_pop ? '0 : w_ld_mask & (~w_ld_mask + NUM_AGEN'(1));
    w_push_req = {replay_valid_i && !recover_i, w_ld_mask & ~w_ld_win};
    w_ld_pkt   = w_pop ? r_fifo[r_rd_ptr] : '0;
    w_st_pkt   = '0;
    w_push_pkt[NUM_AGEN] = replay_pkt_i;
    for (int i = 0; i < NUM_AGEN; i++) begin
      w_push_pkt[i] = agen_pkt_i[i*PKT_W +: PKT_W];
      w_ld_pkt      = w_ld_win[i] ? agen_pkt_i[i*PKT_W +: PKT_W] : w_ld_pkt;
      w_st_pkt      = w_st_win[i] ? agen_pkt_i[i*PKT_W +: PKT_W] : w_st_pkt;
    end
    // the same-cycle pop frees one slot for this cycle's pushes
    w_free     = CW'(REPLAY_DEPTH) - r_count + CW'(w_pop);
    w_npush    = '0;
    w_overflow = 1'b0;
    for (int i = 0; i < NP; i++) begin
      w_wr_idx[i] = r_wr_ptr + AW'(w_npush);
      w_wr_en[i]  = w_push_req[i] && (w_npush < w_free);
      w_overflow  = w_overflow | (w_push_req[i] && !w_wr_en[i]);
      w_npush     = w_npush + CW'(w_wr_en[i]);
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < NP; i++)
      if (w_wr_en[i]) r_fifo[w_wr_idx[i]] <= w_push_pkt[i];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr         <= '0;
      r_wr_ptr         <= '0;
      r_count          <= '0;
      r_starve         <= '0;
      ld_valid_o       <= 1'b0;
      ld_pkt_o         <= '0;
      ld_from_replay_o <= 1'b0;
      st_valid_o       <= 1'b0;
      st_pkt_o         <= '0;
      err_multi_st_o   <= 1'b0;
      err_overflow_o   <= 1'b0;
    end else if (recover_i) begin
      r_rd_ptr         <= '0;
      r_wr_ptr         <= '0;
      r_count          <= '0;
      r_starve         <= '0;
      ld_valid_o       <= 1'b0;
      ld_from_replay_o <= 1'b0;
      st_valid_o       <= 1'b0;
    end else begin
      r_rd_ptr         <= r_rd_ptr + AW'(w_pop);
      r_wr_ptr         <= r_wr_ptr + AW'(w_npush);
      r_count          <= r_count + w_npush - CW'(w_pop);
      r_starve         <= (!w_ne || w_pop) ? '0 : (r_starve == SW'(STARVE_LIMIT) ? r_starve : r_starve + SW'(1));
      ld_valid_o       <= w_pop || w_ld_win != '0;
      ld_pkt_o         <= (w_pop || w_ld_win != '0) ? w_ld_pkt : ld_pkt_o;
      ld_from_replay_o <= w_pop;
      st_valid_o       <= w_st_win != '0;
      st_pkt_o         <= (w_st_win != '0) ? w_st_pkt : st_pkt_o;
      err_multi_st_o   <= err_multi_st_o | ((w_st_mask & ~w_st_win) != '0);
      err_overflow_o   <= err_overflow_o | w_overflow;
    end
  end
endmodule

// File: tb/tb_lsu_issue_arbiter.sv
// tb_lsu_issue_arbiter: directed self-checking bench for lsu_issue_arbiter
module tb_lsu_issue_arbiter;
  logic         clk = 1'b0, reset = 1'b0, recover_i = 1'b0;
  logic [1:0]   agen_valid_i = '0, agen_is_ld_i = '0;
  logic [255:0] agen_pkt_i = '0;
  logic         replay_valid_i = 1'b0;
  logic [127:0] replay_pkt_i = '0;
  logic         agen_ready_o, ld_valid_o, ld_from_replay_o, st_valid_o, err_multi_st_o, err_overflow_o;
  logic [127:0] ld_pkt_o, st_pkt_o;
  logic [3:0]   replay_count_o;
  int n_checks = 0, n_fail = 0;
  lsu_issue_arbiter dut (
    .clk(clk), .reset(reset), .recover_i(recover_i),
    .agen_valid_i(agen_valid_i), .agen_is_ld_i(agen_is_ld_i), .agen_pkt_i(agen_pkt_i),
    .replay_valid_i(replay_valid_i), .replay_pkt_i(replay_pkt_i),
    .agen_ready_o(agen_ready_o), .ld_valid_o(ld_valid_o), .ld_pkt_o(ld_pkt_o),
    .ld_from_replay_o(ld_from_replay_o), .st_valid_o(st_valid_o), .st_pkt_o(st_pkt_o),
    .replay_count_o(replay_count_o), .err_multi_st_o(err_multi_st_o), .err_overflow_o(err_overflow_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] pk(input int k);
    return {96'hDEADBEEF_CAFEF00D_12345678, 32'(k)};
  endfunction
  task automatic drv(input logic [1:0] v, input logic [1:0] ld, input int k0, input int k1, input logic rv, input int kr);
    agen_valid_i   = v;
    agen_is_ld_i   = ld;
    agen_pkt_i     = {pk(k1), pk(k0)};
    replay_valid_i = rv;
    replay_pkt_i   = pk(kr);
  endtask
  task automatic idle();
    drv(2'b00, 2'b00, 0, 0, 1'b0, 0);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2 reset = 1'b1;
    step();
    check("rst_ld_valid", ld_valid_o, 0);
    check("rst_st_valid", st_valid_o, 0);
    check("rst_count", replay_count_o, 0);
    check("rst_ready", agen_ready_o, 1);
    reset = 1'b0;
    step();
    // load on ch0, store on ch1
    drv(2'b11, 2'b01, 10, 11, 1'b0, 0);
    step();
    idle();
    check("ldst_ld_valid", ld_valid_o, 1);
    check("ldst_ld_pkt", ld_pkt_o, pk(10));
    check("ldst_from_rp", ld_from_replay_o, 0);
    check("ldst_st_valid", st_valid_o, 1);
    check("ldst_st_pkt", st_pkt_o, pk(11));
    check("ldst_count", replay_count_o, 0);
    // two loads: ch1 goes through the FIFO
    drv(2'b11, 2'b11, 20, 21, 1'b0, 0);
    step();
    idle();
    check("ll_pkt0", ld_pkt_o, pk(20));
    check("ll_count1", replay_count_o, 1);
    check("ll_st_valid", st_valid_o, 0);
    step();
    check("ll_valid1", ld_valid_o, 1);
    check("ll_pkt1", ld_pkt_o, pk(21));
    check("ll_from_rp1", ld_from_replay_o, 1);
    check("ll_count0", replay_count_o, 0);
    step();
    check("ll_idle", ld_valid_o, 0);
    // starvation: R buffered, then ch0 loads every cycle
    drv(2'b00, 2'b00, 0, 0, 1'b1, 30);
    step();
    check("sv_count", replay_count_o, 1);
    check("sv_no_issue", ld_valid_o, 0);
    for (int k = 0; k < 4; k++) begin
      drv(2'b01, 2'b01, 40 + k, 0, 1'b0, 0);
      step();
      check($sformatf("sv_agen%0d", k), ld_pkt_o, pk(40 + k));
      check($sformatf("sv_agen_rp%0d", k), ld_from_replay_o, 0);
    end
    drv(2'b01, 2'b01, 44, 0, 1'b0, 0);
    step();
    idle();
    check("sv_forced_pkt", ld_pkt_o, pk(30));
    check("sv_forced_rp", ld_from_replay_o, 1);
    check("sv_forced_count", replay_count_o, 1);
    step();
    check("sv_drain_pkt", ld_pkt_o, pk(44));
    check("sv_drain_rp", ld_from_replay_o, 1);
    check("sv_drain_count", replay_count_o, 0);
    // two stores in one cycle
    drv(2'b11, 2'b00, 50, 51, 1'b0, 0);
    step();
    idle();
    check("ms_st_valid", st_valid_o, 1);
    check("ms_st_pkt", st_pkt_o, pk(50));
    check("ms_err", err_multi_st_o, 1);
    check("ms_ld_valid", ld_valid_o, 0);
    step();
    check("ms_err_held", err_multi_st_o, 1);
    check("ms_st_idle", st_valid_o, 0);
    // occupancy and agen_ready
    drv(2'b11, 2'b11, 60, 61, 1'b1, 62);
    step();
    check("oc_count2", replay_count_o, 2);
    drv(2'b11, 2'b11, 63, 64, 1'b1, 65);
    step();
    check("oc_count4", replay_count_o, 4);
    drv(2'b01, 2'b01, 66, 0, 1'b1, 67);
    step();
    check("oc_count5", replay_count_o, 5);
    check("oc_ready5", agen_ready_o, 1);
    drv(2'b01, 2'b01, 68, 0, 1'b1, 69);
    step();
    check("oc_count6", replay_count_o, 6);
    check("oc_ready6", agen_ready_o, 0);
    drv(2'b01, 2'b01, 70, 0, 1'b1, 71);
    recover_i = 1'b1;
    step();
    recover_i = 1'b0;
    idle();
    check("oc_rec_count", replay_count_o, 0);
    // recover with count=3 and a valid ch0 load
    drv(2'b11, 2'b11, 80, 81, 1'b1, 82);
    step();
    drv(2'b01, 2'b01, 83, 0, 1'b1, 84);
    step();
    check("rc_count3", replay_count_o, 3);
    drv(2'b01, 2'b01, 85, 0, 1'b1, 86);
    recover_i = 1'b1;
    step();
    recover_i = 1'b0;
    idle();
    check("rc_ld_valid", ld_valid_o, 0);
    check("rc_from_rp", ld_from_replay_o, 0);
    check("rc_count", replay_count_o, 0);
    check("rc_err_kept", err_multi_st_o, 1);
    step();
    check("rc_no_issue", ld_valid_o, 0);
    check("rc_still_empty", replay_count_o, 0);
    // async reset mid-traffic with count=3
    drv(2'b11, 2'b11, 90, 91, 1'b1, 92);
    step();
    drv(2'b01, 2'b01, 93, 0, 1'b1, 94);
    step();
    check("ar_count3", replay_count_o, 3);
    drv(2'b01, 2'b01, 95, 0, 1'b1, 96);
    #2 reset = 1'b1;
    #1;
    check("ar_ld_valid", ld_valid_o, 0);
    check("ar_ld_pkt", ld_pkt_o, 0);
    check("ar_st_pkt", st_pkt_o, 0);
    check("ar_count", replay_count_o, 0);
    check("ar_ready", agen_ready_o, 1);
    check("ar_err_multi", err_multi_st_o, 0);
    step();
    reset = 1'b0;
    idle();
    step();
    check("ar_discard_valid", ld_valid_o, 0);
    check("ar_discard_count", replay_count_o, 0);
    // fill to 8 without a pop, then overflow
    for (int k = 0; k < 4; k++) begin
      drv(2'b11, 2'b11, 100 + 3*k, 101 + 3*k, 1'b1, 102 + 3*k);
      step();
    end
    check("of_count8", replay_count_o, 8);
    check("of_ready8", agen_ready_o, 0);
    check("of_err_pre", err_overflow_o, 0);
    drv(2'b11, 2'b11, 112, 113, 1'b1, 114);
    step();
    idle();
    check("of_err", err_overflow_o, 1);
    check("of_ld_pkt", ld_pkt_o, pk(112));
    check("of_count_held", replay_count_o, 8);
    step();
    check("of_head_pkt", ld_pkt_o, pk(101));
    check("of_head_rp", ld_from_replay_o, 1);
    check("of_count7", replay_count_o, 7);
    check("of_err_held", err_overflow_o, 1);
    step();
    check("of_next_pkt", ld_pkt_o, pk(102));
    check("of_count6", replay_count_o, 6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
